// File: rtl/mpi_eth_rx_responder.sv
// MPI-over-Ethernet RX endpoint: header parse/filter, payload forward, 3-beat DONE reply.
// Optional statistics counters are built when MPI_RX_STATS_EN is defined.
module mpi_eth_rx_responder #(
    parameter logic [47:0] MAC_ADDR_FPGA = 48'hfa163e55ca02,
    parameter logic [15:0] MY_RANK       = 16'd1,
    parameter logic [15:0] ETHERTYPE     = 16'h7400,
    parameter int unsigned SIZE_W        = 32
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic [63:0] rx_in_data,
    input  logic [7:0]  rx_in_keep,
    input  logic        rx_in_last,
    input  logic        rx_in_valid,
    output logic        rx_in_ready,
    output logic [63:0] pl_out_data,
    output logic [7:0]  pl_out_keep,
    output logic        pl_out_last,
    output logic        pl_out_valid,
    input  logic        pl_out_ready,
    output logic [63:0] tx_out_data,
    output logic [7:0]  tx_out_keep,
    output logic        tx_out_last,
    output logic        tx_out_valid,
    input  logic        tx_out_ready,
    output logic        err_trunc,
    output logic [15:0] stat_accept,
    output logic [15:0] stat_drop
);

    typedef enum logic [2:0] {
        StHdr0,
        StHdr1,
        StHdr2,
        StPayload,
        StDone0,
        StDone1,
        StDone2,
        StDrop
    } state_e;

    state_e              r_state;
    logic [47:0]         r_dst_mac;
    logic [47:0]         r_src_mac;
    logic [15:0]         r_dst_rank;
    logic [7:0]          r_src_rank;
    logic                r_size_odd;
    logic [SIZE_W-1:0]   r_beats;
    logic                r_err_trunc;

    logic                w_rx_hs;
    logic                w_final;
    logic                w_pass;
    logic [SIZE_W-1:0]   w_h2_size;
    logic [SIZE_W-1:0]   w_h2_beats;

    assign w_rx_hs    = rx_in_valid & rx_in_ready;
    assign w_final    = (r_beats == SIZE_W'(1));
    assign w_h2_size  = rx_in_data[SIZE_W-1:0];
    // ceil(size/2) without needing an extra carry bit
    assign w_h2_beats = {1'b0, w_h2_size[SIZE_W-1:1]} + {{(SIZE_W-1){1'b0}}, w_h2_size[0]};
    assign w_pass     = (r_dst_mac == MAC_ADDR_FPGA) && (r_dst_rank == MY_RANK) &&
                        (rx_in_data[55:48] == 8'h01);
    assign err_trunc  = r_err_trunc;

    always_comb begin
        rx_in_ready  = 1'b0;
        pl_out_data  = '0;
        pl_out_keep  = '0;
        pl_out_last  = 1'b0;
        pl_out_valid = 1'b0;
        tx_out_data  = '0;
        tx_out_keep  = '0;
        tx_out_last  = 1'b0;
        tx_out_valid = 1'b0;
        unique case (r_state)
            StHdr0, StHdr1, StHdr2, StDrop: begin
                // Ready is held low for the whole reset assertion
                rx_in_ready = aresetn;
            end
            StPayload: begin
                rx_in_ready  = pl_out_ready;
                pl_out_valid = rx_in_valid;
                pl_out_data  = rx_in_data;
                pl_out_last  = w_final | rx_in_last;
                pl_out_keep  = (w_final && r_size_odd) ? (rx_in_keep & 8'hF0) : rx_in_keep;
            end
            StDone0: begin
                tx_out_valid = 1'b1;
                tx_out_keep  = 8'hFF;
                tx_out_data  = {r_src_mac, MAC_ADDR_FPGA[47:32]};
            end
            StDone1: begin
                tx_out_valid = 1'b1;
                tx_out_keep  = 8'hFF;
                tx_out_data  = {MAC_ADDR_FPGA[31:0], ETHERTYPE, 8'h00, r_src_rank};
            end
            StDone2: begin
                tx_out_valid = 1'b1;
                tx_out_keep  = 8'hFF;
                tx_out_last  = 1'b1;
                tx_out_data  = {MY_RANK[7:0], 8'h02, 16'h0000, 32'h0000_0000};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= StHdr0;
            r_dst_mac   <= '0;
            r_src_mac   <= '0;
            r_dst_rank  <= '0;
            r_src_rank  <= '0;
            r_size_odd  <= 1'b0;
            r_beats     <= '0;
            r_err_trunc <= 1'b0;
        end else begin
            r_err_trunc <= 1'b0;
            unique case (r_state)
                StHdr0: begin
                    if (w_rx_hs) begin
                        r_dst_mac        <= rx_in_data[63:16];
                        r_src_mac[47:32] <= rx_in_data[15:0];
                        r_state          <= rx_in_last ? StHdr0 : StHdr1;
                    end
                end
                StHdr1: begin
                    if (w_rx_hs) begin
                        r_src_mac[31:0] <= rx_in_data[63:32];
                        r_dst_rank      <= rx_in_data[15:0];
                        r_state         <= rx_in_last ? StHdr0 : StHdr2;
                    end
                end
                StHdr2: begin
                    if (w_rx_hs) begin
                        r_src_rank <= rx_in_data[63:56];
                        r_size_odd <= rx_in_data[0];
                        r_beats    <= w_h2_beats;
                        if (!w_pass) begin
                            r_state <= rx_in_last ? StHdr0 : StDrop;
                        end else if (w_h2_size == '0) begin
                            r_state <= rx_in_last ? StDone0 : StDrop;
                        end else if (rx_in_last) begin
                            r_state     <= StHdr0;
                            r_err_trunc <= 1'b1;
                        end else begin
                            r_state <= StPayload;
                        end
                    end
                end
                StPayload: begin
                    if (w_rx_hs) begin
                        if (w_final) begin
                            r_state <= rx_in_last ? StDone0 : StDrop;
                        end else if (rx_in_last) begin
                            r_state     <= StHdr0;
                            r_err_trunc <= 1'b1;
                        end else begin
                            r_beats <= r_beats - SIZE_W'(1);
                        end
                    end
                end
                StDrop: begin
                    if (w_rx_hs && rx_in_last) begin
                        r_state <= StHdr0;
                    end
                end
                StDone0: if (tx_out_ready) r_state <= StDone1;
                StDone1: if (tx_out_ready) r_state <= StDone2;
                StDone2: if (tx_out_ready) r_state <= StHdr0;
                default: r_state <= StHdr0;
            endcase
        end
    end

`ifdef MPI_RX_STATS_EN
    logic        w_acc_evt;
    logic        w_drop_evt;
    logic [15:0] r_stat_accept;
    logic [15:0] r_stat_drop;

    assign w_acc_evt  = w_rx_hs && (((r_state == StHdr2) && w_pass && (w_h2_size == '0)) ||
                                    ((r_state == StPayload) && w_final));
    assign w_drop_evt = w_rx_hs && ((((r_state == StHdr0) || (r_state == StHdr1)) && rx_in_last) ||
                                    ((r_state == StHdr2) && !w_pass));

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_stat_accept <= '0;
            r_stat_drop   <= '0;
        end else begin
            if (w_acc_evt && (r_stat_accept != 16'hFFFF)) r_stat_accept <= r_stat_accept + 16'd1;
            if (w_drop_evt && (r_stat_drop != 16'hFFFF)) r_stat_drop <= r_stat_drop + 16'd1;
        end
    end

    assign stat_accept = r_stat_accept;
    assign stat_drop   = r_stat_drop;
`else
    assign stat_accept = 16'h0;
    assign stat_drop   = 16'h0;
`endif

endmodule

// File: tb/tb_mpi_eth_rx_responder.sv
// Directed bench for mpi_eth_rx_responder with a frame-level reference model and a per-cycle
// output comparator.
module tb_mpi_eth_rx_responder;

    localparam logic [47:0] OWN_MAC = 48'hfa163e55ca02;
    localparam logic [47:0] SRC_MAC = 48'h0cc47a88c047;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic [63:0] rx_in_data = '0;
    logic [7:0]  rx_in_keep = '0;
    logic        rx_in_last = 1'b0;
    logic        rx_in_valid = 1'b0;
    logic        rx_in_ready;
    logic [63:0] pl_out_data;
    logic [7:0]  pl_out_keep;
    logic        pl_out_last;
    logic        pl_out_valid;
    logic        pl_out_ready = 1'b1;
    logic [63:0] tx_out_data;
    logic [7:0]  tx_out_keep;
    logic        tx_out_last;
    logic        tx_out_valid;
    logic        tx_out_ready = 1'b0;
    logic        err_trunc;
    logic [15:0] stat_accept;
    logic [15:0] stat_drop;

    mpi_eth_rx_responder dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .rx_in_data   (rx_in_data),
        .rx_in_keep   (rx_in_keep),
        .rx_in_last   (rx_in_last),
        .rx_in_valid  (rx_in_valid),
        .rx_in_ready  (rx_in_ready),
        .pl_out_data  (pl_out_data),
        .pl_out_keep  (pl_out_keep),
        .pl_out_last  (pl_out_last),
        .pl_out_valid (pl_out_valid),
        .pl_out_ready (pl_out_ready),
        .tx_out_data  (tx_out_data),
        .tx_out_keep  (tx_out_keep),
        .tx_out_last  (tx_out_last),
        .tx_out_valid (tx_out_valid),
        .tx_out_ready (tx_out_ready),
        .err_trunc    (err_trunc),
        .stat_accept  (stat_accept),
        .stat_drop    (stat_drop)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    beat_t       pl_q[$];
    beat_t       tx_q[$];
    int          m_acc = 0;
    int          m_drop = 0;
    int          m_trunc = 0;
    int          seen_trunc = 0;
    int          tx_total = 0;
    logic        prev_trunc = 1'b0;
    logic [63:0] last_pl_d = '0;
    logic [7:0]  last_pl_k = '0;
    logic [63:0] tx_seen[3];
    logic [63:0] fr_d[16];
    logic [7:0]  fr_k[16];
    int          fr_n = 0;
    bit          pl_toggle = 0;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Kernel-side backpressure pattern
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (pl_toggle) pl_out_ready = ~pl_out_ready;
            else pl_out_ready = 1'b1;
        end
    end

    // Network TX stalls 5 cycles at the start of every DONE reply
    initial begin
        int stall;
        stall = 0;
        forever begin
            @(posedge clk);
            #1;
            if (tx_out_valid) begin
                if (stall < 5) begin
                    tx_out_ready = 1'b0;
                    stall++;
                end else begin
                    tx_out_ready = 1'b1;
                end
            end else begin
                stall = 0;
                tx_out_ready = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!aresetn) begin
            check("rst_ctrl", 64'({pl_out_valid, pl_out_last, tx_out_valid, tx_out_last,
                                   err_trunc, rx_in_ready}), 64'h0);
            check("rst_data", pl_out_data | tx_out_data, 64'h0);
            check("rst_keep_stats", 64'({pl_out_keep, tx_out_keep, stat_accept, stat_drop}),
                  64'h0);
        end else begin
            if (pl_out_valid) begin
                if (pl_q.size() == 0) begin
                    check("pl_unexpected", 64'(pl_out_valid), 64'h0);
                end else begin
                    check("pl_data", pl_out_data, pl_q[0].d);
                    check("pl_keep", 64'(pl_out_keep), 64'(pl_q[0].k));
                    check("pl_last", 64'(pl_out_last), 64'(pl_q[0].l));
                    if (pl_out_ready) begin
                        last_pl_d = pl_out_data;
                        last_pl_k = pl_out_keep;
                        void'(pl_q.pop_front());
                    end
                end
            end
            if (tx_out_valid) begin
                check("rx_ready_in_done", 64'(rx_in_ready), 64'h0);
                if (tx_q.size() == 0) begin
                    check("tx_unexpected", 64'(tx_out_valid), 64'h0);
                end else begin
                    check("tx_data", tx_out_data, tx_q[0].d);
                    check("tx_keep", 64'(tx_out_keep), 64'(tx_q[0].k));
                    check("tx_last", 64'(tx_out_last), 64'(tx_q[0].l));
                    if (tx_out_ready) begin
                        tx_seen[tx_total % 3] = tx_out_data;
                        tx_total++;
                        void'(tx_q.pop_front());
                    end
                end
            end
            if (err_trunc) begin
                check("trunc_pulse_width", 64'(prev_trunc), 64'h0);
                seen_trunc++;
            end
            prev_trunc = err_trunc;
        end
    end

    task automatic build_frame(input logic [47:0] dmac, input logic [15:0] drank,
                               input logic [7:0] mtype, input logic [31:0] size,
                               input logic [7:0] srank, input int npl);
        fr_d[0] = {dmac, SRC_MAC[47:32]};
        fr_d[1] = {SRC_MAC[31:0], 16'h7400, drank};
        fr_d[2] = {srank, mtype, 16'h0000, size};
        for (int i = 0; i < npl; i++) fr_d[3+i] = 64'hA5A5_0000_0000_0000 + 64'(i);
        for (int i = 0; i < 16; i++) fr_k[i] = 8'hFF;
        fr_n = 3 + npl;
    endtask

    task automatic push_done(input logic [7:0] srank);
        tx_q.push_back('{d: {SRC_MAC, OWN_MAC[47:32]}, k: 8'hFF, l: 1'b0});
        tx_q.push_back('{d: {OWN_MAC[31:0], 16'h7400, 8'h00, srank}, k: 8'hFF, l: 1'b0});
        tx_q.push_back('{d: {8'h01, 8'h02, 48'h0}, k: 8'hFF, l: 1'b1});
    endtask

    // Frame-level reference: what a whole frame must produce, by the field rules
    task automatic model_frame();
        logic [47:0] dmac;
        logic [15:0] drank;
        logic [7:0]  mtype;
        logic [7:0]  srank;
        logic [31:0] size;
        longint      n;
        int          avail;
        if (fr_n < 3) begin
            m_drop++;
            return;
        end
        dmac  = fr_d[0][63:16];
        drank = fr_d[1][15:0];
        mtype = fr_d[2][55:48];
        srank = fr_d[2][63:56];
        size  = fr_d[2][31:0];
        if (dmac != OWN_MAC || drank != 16'd1 || mtype != 8'h01) begin
            m_drop++;
            return;
        end
        n = (longint'(size) + 1) / 2;
        avail = fr_n - 3;
        if (n == 0) begin
            m_acc++;
            if (avail == 0) push_done(srank);
            return;
        end
        if (avail == 0) begin
            m_trunc++;
            return;
        end
        for (int i = 0; i < avail && i < n; i++) begin
            beat_t b;
            b.d = fr_d[3+i];
            b.k = fr_k[3+i];
            b.l = (i == n - 1) || (i == avail - 1);
            if (i == n - 1 && size[0]) b.k = b.k & 8'hF0;
            pl_q.push_back(b);
        end
        if (avail >= n) begin
            m_acc++;
            if (avail == n) push_done(srank);
        end else begin
            m_trunc++;
        end
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        int cyc;
        bit ok;
        cyc = 0;
        ok = 0;
        rx_in_data  = d;
        rx_in_keep  = k;
        rx_in_last  = l;
        rx_in_valid = 1'b1;
        while (!ok && cyc < 300) begin
            @(negedge clk);
            if (rx_in_ready) ok = 1;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!ok) check("rx_handshake_timeout", 64'(ok), 64'h1);
        rx_in_valid = 1'b0;
        rx_in_last  = 1'b0;
    endtask

    task automatic send_frame();
        for (int i = 0; i < fr_n; i++) send_beat(fr_d[i], fr_k[i], (i == fr_n - 1));
    endtask

    task automatic run_frame();
        model_frame();
        send_frame();
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while ((pl_q.size() != 0 || tx_q.size() != 0 || tx_out_valid) && c < 1000) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (c >= 1000) check("idle_timeout", 64'(c), 64'h0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_stats(input string tag);
`ifdef MPI_RX_STATS_EN
        check({tag, "_stat_accept"}, 64'(stat_accept), 64'(m_acc));
        check({tag, "_stat_drop"}, 64'(stat_drop), 64'(m_drop));
`else
        check({tag, "_stat_accept"}, 64'(stat_accept), 64'h0);
        check({tag, "_stat_drop"}, 64'(stat_drop), 64'h0);
`endif
        check({tag, "_trunc_count"}, 64'(seen_trunc), 64'(m_trunc));
        check({tag, "_idle_ready"}, 64'(rx_in_ready), 64'h1);
    endtask

    initial begin
        int tx_base;
        int trunc_base;
        beat_t b;
        repeat (3) @(posedge clk);
        #1;
        aresetn = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_ready", 64'(rx_in_ready), 64'h1);
        check("post_reset_tx_valid", 64'(tx_out_valid), 64'h0);

        // 1: basic accepted message
        tx_base = tx_total;
        build_frame(OWN_MAC, 16'd1, 8'h01, 32'd2, 8'h00, 1);
        fr_d[3] = 64'h4100_0000_0000_0000;
        run_frame();
        wait_idle();
        check_stats("t1");
        check("t1_pl_data_lit", last_pl_d, 64'h4100_0000_0000_0000);
        check("t1_pl_keep_lit", 64'(last_pl_k), 64'hFF);
        check("t1_tx_beats", 64'(tx_total - tx_base), 64'd3);
        check("t1_done0_lit", tx_seen[0], 64'h0cc4_7a88_c047_fa16);
        check("t1_done1_lit", tx_seen[1], 64'h3e55_ca02_7400_0000);
        check("t1_done2_lit", tx_seen[2], 64'h0102_0000_0000_0000);

        // 2: wrong destination MAC is dropped
        tx_base = tx_total;
        build_frame(48'h1111_1111_1111, 16'd1, 8'h01, 32'd2, 8'h00, 1);
        run_frame();
        wait_idle();
        check_stats("t2");
        check("t2_no_done", 64'(tx_total - tx_base), 64'd0);

        // 3: two payload beats under kernel backpressure
        pl_toggle = 1;
        build_frame(OWN_MAC, 16'd1, 8'h01, 32'd4, 8'h05, 2);
        run_frame();
        wait_idle();
        pl_toggle = 0;
        check_stats("t3");
        check("t3_pl_last_data", last_pl_d, 64'hA5A5_0000_0000_0001);

        // 4: odd size masks the low word of the final beat
        build_frame(OWN_MAC, 16'd1, 8'h01, 32'd3, 8'h00, 2);
        run_frame();
        wait_idle();
        check_stats("t4");
        check("t4_keep_lit", 64'(last_pl_k), 64'hF0);

        // 5: frame ends before size satisfied
        tx_base = tx_total;
        trunc_base = seen_trunc;
        build_frame(OWN_MAC, 16'd1, 8'h01, 32'd4, 8'h00, 1);
        run_frame();
        wait_idle();
        check_stats("t5");
        check("t5_trunc_pulses", 64'(seen_trunc - trunc_base), 64'd1);
        check("t5_no_done", 64'(tx_total - tx_base), 64'd0);

        // 6: reset mid-payload, then leftovers and a clean frame
        build_frame(OWN_MAC, 16'd1, 8'h01, 32'd4, 8'h00, 2);
        b = '{d: fr_d[3], k: 8'hFF, l: 1'b0};
        pl_q.push_back(b);
        for (int i = 0; i < 4; i++) send_beat(fr_d[i], fr_k[i], 1'b0);
        wait_idle();
        aresetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        aresetn = 1'b1;
        m_acc = 0;
        m_drop = 0;
        fr_d[0] = fr_d[4];
        fr_n = 1;
        run_frame();
        wait_idle();
        check_stats("t6_leftover");
        tx_base = tx_total;
        build_frame(OWN_MAC, 16'd1, 8'h01, 32'd2, 8'h00, 1);
        fr_d[3] = 64'h4100_0000_0000_0000;
        run_frame();
        wait_idle();
        check_stats("t6_clean");
        check("t6_tx_beats", 64'(tx_total - tx_base), 64'd3);
        check("t6_pl_data_lit", last_pl_d, 64'h4100_0000_0000_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
